// File: rtl/clusterv_cfg_chain_ctrl.sv
// clusterv_cfg_chain_ctrl: shifts the config buffer through the tile chain and captures the old chain contents
module clusterv_cfg_chain_ctrl #(
    parameter int          N_TILES        = 4,
    parameter int          IDX_WIDTH      = 3,
    parameter logic [31:0] HARTID_BASE    = 32'h0000_0000,
    parameter logic [31:0] RESVEC_DEFAULT = 32'h8000_0000
) (
    input  logic                 cfg_sclk,
    input  logic                 sys_reset,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [IDX_WIDTH-1:0] rd_addr,
    output logic [31:0]          rd_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_sdi,
    input  logic                 cfg_sdo,
    output logic                 chain_clk_en
);
    localparam int NW = 2 * N_TILES;
    localparam int NB = 64 * N_TILES;
    localparam int CW = $clog2(NB);
    localparam int NA = 2 ** IDX_WIDTH;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_nxt;
    logic [31:0] cfg_w [NA];
    logic [31:0] rb_w [NA];
    logic [CW-1:0] cnt, nxt;
    logic [IDX_WIDTH-1:0] cw, nw;
    logic go, fin, wr_ok, bit0, bitn;
    always_comb begin
        nxt = cnt + 1'b1;
        cw = IDX_WIDTH'(cnt >> 5);
        nw = IDX_WIDTH'(nxt >> 5);
        wr_ok = wr_en && state == IDLE && int'(wr_addr) < NW;
        go = state == IDLE && start;
        fin = state == SHIFT && cnt == CW'(NB - 1);
        bit0 = (wr_ok && wr_addr == '0) ? wr_data[0] : cfg_w[0][0];
        bitn = cfg_w[nw][nxt[4:0]];
        state_nxt = go ? SHIFT : fin ? IDLE : state;
    end
    assign rd_data = int'(rd_addr) < NW ? rb_w[rd_addr] : '0;
    always_ff @(posedge cfg_sclk or posedge sys_reset) begin
        if (sys_reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge cfg_sclk or posedge sys_reset) begin
        if (sys_reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            cfg_sdi <= 1'b0;
            chain_clk_en <= 1'b0;
            cnt <= '0;
            for (int i = 0; i < NA; i++) begin
                cfg_w[i] <= i >= NW ? '0 : i[0] ? RESVEC_DEFAULT : HARTID_BASE + 32'(i / 2);
                rb_w[i] <= '0;
            end
        end else begin
            done <= fin;
            if (wr_ok) cfg_w[wr_addr] <= wr_data;
            if (go) begin
                busy <= 1'b1;
                chain_clk_en <= 1'b1;
                cfg_sdi <= bit0;
                cnt <= '0;
            end
            if (state == SHIFT) begin
                rb_w[cw][cnt[4:0]] <= cfg_sdo;
                cnt <= fin ? '0 : nxt;
                cfg_sdi <= fin ? 1'b0 : bitn;
                if (fin) begin
                    busy <= 1'b0;
                    chain_clk_en <= 1'b0;
                end
            end
        end
    end
endmodule
